// File: rtl/msi_pkg.sv
// Shared MSI bus definitions: command encodings, default bus geometry and
// the memory responder's state type.
package msi_pkg;

  localparam int ADDR_SIZE_DEF       = 32;
  localparam int CACHE_LINE_SIZE_DEF = 128;

  typedef enum logic [1:0] {
    CMD_RD    = 2'd0,
    CMD_RDX   = 2'd1,
    CMD_UPGR  = 2'd2,
    CMD_FLUSH = 2'd3
  } bus_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_RESPOND,
    ST_WRITE
  } resp_state_e;

endpackage

// File: rtl/bus_mem_responder_if.sv
// Snooping-bus view of the memory responder: the granted command, the
// intervention path and the responder's read-data/status outputs.
interface bus_mem_responder_if
  import msi_pkg::*;
#(
  parameter int ADDR_SIZE       = ADDR_SIZE_DEF,
  parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEF
) ();

  logic                       bus_valid_i;
  logic [1:0]                 bus_cmd_i;
  logic [ADDR_SIZE-1:0]       bus_addr_i;
  logic [CACHE_LINE_SIZE-1:0] bus_data_i;
  logic                       bus_flush_i;
  logic                       mem_busy_o;
  logic                       resp_valid_o;
  logic [CACHE_LINE_SIZE-1:0] resp_data_o;
  logic [ADDR_SIZE-1:0]       resp_addr_o;
  logic                       err_o;

  modport master (
    output bus_valid_i, bus_cmd_i, bus_addr_i, bus_data_i, bus_flush_i,
    input  mem_busy_o, resp_valid_o, resp_data_o, resp_addr_o, err_o
  );

  modport slave (
    input  bus_valid_i, bus_cmd_i, bus_addr_i, bus_data_i, bus_flush_i,
    output mem_busy_o, resp_valid_o, resp_data_o, resp_addr_o, err_o
  );

endinterface

// File: rtl/bus_mem_responder_mem_array.sv
// Backing store: LINES x WIDTH, synchronous write, combinational read on a
// shared line index.
module mem_array #(
  parameter int LINES = 16,
  parameter int WIDTH = 128,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [LINES];

  // NOTE: the array has no reset; contents survive rst_i and start undefined,
  // which also lets synthesis map it onto RAM.
  // NOTE: clocked state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory responder on the MSI snooping bus: fixed-latency line reads with
// cache intervention, line write-back, and a sticky protocol-error flag.
module bus_mem_responder
  import msi_pkg::*;
#(
  parameter int ADDR_SIZE       = ADDR_SIZE_DEF,
  parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEF,
  parameter int MEM_LINES       = 16,
  parameter int MEM_LATENCY     = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  bus_mem_responder_if.slave bus
);

  localparam int OFF   = $clog2(CACHE_LINE_SIZE / 8);
  localparam int IDX   = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(MEM_LATENCY);

  typedef logic [ADDR_SIZE-OFF-1:0] line_t;

  resp_state_e                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  line_t                      line_q, line_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [CACHE_LINE_SIZE-1:0] resp_data_q, resp_data_d;
  logic [ADDR_SIZE-1:0]       resp_addr_q, resp_addr_d;
  logic                       err_q, err_d;

  logic                       mem_we;
  logic [CACHE_LINE_SIZE-1:0] mem_wdata;
  logic [CACHE_LINE_SIZE-1:0] mem_rdata;
  line_t                      bus_line;
  logic                       flush_hit;

  assign bus_line  = bus.bus_addr_i[ADDR_SIZE-1:OFF];
  assign flush_hit = (state_q == ST_READ_WAIT) && bus.bus_flush_i && (bus_line == line_q);

  mem_array #(
    .LINES(MEM_LINES),
    .WIDTH(CACHE_LINE_SIZE)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .idx_i  (line_q[IDX-1:0]),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_addr_d  = '0;
    err_d        = err_q | (bus.bus_valid_i && (state_q != ST_IDLE));
    mem_we       = 1'b0;
    mem_wdata    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.bus_valid_i) begin
          case (bus_cmd_e'(bus.bus_cmd_i))
            CMD_RD, CMD_RDX: begin
              line_d  = bus_line;
              cnt_d   = CNT_W'(MEM_LATENCY - 2);
              state_d = ST_READ_WAIT;
            end
            CMD_FLUSH: begin
              line_d  = bus_line;
              wdata_d = bus.bus_data_i;
              state_d = ST_WRITE;
            end
            default: ;  // UPGR is a pure coherence action, memory stays out
          endcase
        end
      end
      ST_READ_WAIT: begin
        if (flush_hit) begin
          // A modified copy supplies the line: adopt it and drop the response.
          mem_we    = 1'b1;
          mem_wdata = bus.bus_data_i;
          state_d   = ST_IDLE;
        end else if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_data_d  = mem_rdata;
          resp_addr_d  = {line_q, {OFF{1'b0}}};
          state_d      = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      ST_WRITE: begin
        mem_we  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_addr_q  <= resp_addr_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_busy_o   = (state_q != ST_IDLE);
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_data_o  = resp_data_q;
  assign bus.resp_addr_o  = resp_addr_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed vector table, error
// and reset sequences, then random traffic against a line-level memory model.
module tb_bus_mem_responder;
  import msi_pkg::*;

  localparam int LAT = 4;

  typedef struct {
    logic [1:0]   cmd;
    logic [31:0]  addr;
    logic [127:0] data;
    int           fcyc;      // cycle after accept that carries a flush, 0 = none
    logic [31:0]  faddr;
    logic [127:0] fdata;
    logic         exp_resp;
    logic [127:0] exp_data;
    logic [31:0]  exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_mem_responder_if #(.ADDR_SIZE(32), .CACHE_LINE_SIZE(128)) bus ();

  bus_mem_responder #(
    .ADDR_SIZE      (32),
    .CACHE_LINE_SIZE(128),
    .MEM_LINES      (16),
    .MEM_LATENCY    (LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int           tests = 0;
  int           fails = 0;
  logic [127:0] ref_mem [16];
  vec_t         vecs    [12];

  task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.bus_valid_i = 1'b0;
    bus.bus_cmd_i   = 2'd0;
    bus.bus_addr_i  = '0;
    bus.bus_data_i  = '0;
    bus.bus_flush_i = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic vec_t mk(input logic [1:0] cmd, input logic [31:0] addr,
                              input logic [127:0] data, input int fcyc,
                              input logic [31:0] faddr, input logic [127:0] fdata,
                              input logic exp_resp, input logic [127:0] exp_data,
                              input logic [31:0] exp_addr);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.data = data; v.fcyc = fcyc;
    v.faddr = faddr; v.fdata = fdata; v.exp_resp = exp_resp;
    v.exp_data = exp_data; v.exp_addr = exp_addr;
    return v;
  endfunction

  // Called at a falling edge with the responder idle; returns at a falling
  // edge with the responder idle again.
  task automatic run_txn(input string tag, input vec_t v);
    logic ended, fire;
    bus.bus_valid_i = 1'b1;
    bus.bus_cmd_i   = v.cmd;
    bus.bus_addr_i  = v.addr;
    bus.bus_data_i  = v.data;
    bus.bus_flush_i = 1'b0;
    @(negedge clk);
    drive_idle();
    if (v.cmd == CMD_UPGR) begin
      check1({tag, ".upgr_busy"}, bus.mem_busy_o, 1'b0);
      check1({tag, ".upgr_rv"}, bus.resp_valid_o, 1'b0);
    end else if (v.cmd == CMD_FLUSH) begin
      check1({tag, ".wr_busy"}, bus.mem_busy_o, 1'b1);
      @(negedge clk);
      check1({tag, ".wr_done"}, bus.mem_busy_o, 1'b0);
    end else begin
      for (int c = 1; c <= LAT; c++) begin
        ended = !v.exp_resp && (v.fcyc != 0) && (c > v.fcyc);
        fire  = v.exp_resp && (c == LAT);
        check1({tag, ".busy"}, bus.mem_busy_o, !ended);
        check1({tag, ".rv"}, bus.resp_valid_o, fire);
        check_v({tag, ".data"}, bus.resp_data_o, fire ? v.exp_data : 128'd0);
        check_v({tag, ".addr"}, 128'(bus.resp_addr_o), fire ? 128'(v.exp_addr) : 128'd0);
        if (c == v.fcyc) begin
          bus.bus_flush_i = 1'b1;
          bus.bus_addr_i  = v.faddr;
          bus.bus_data_i  = v.fdata;
        end else begin
          drive_idle();
        end
        @(negedge clk);
      end
      check1({tag, ".end_busy"}, bus.mem_busy_o, 1'b0);
      check1({tag, ".end_rv"}, bus.resp_valid_o, 1'b0);
    end
  endtask

  initial begin
    logic [127:0] a5, d, fd;
    logic [31:0]  a, fa;
    logic [3:0]   idx;
    int           op, fc;
    logic         hit;

    a5 = {16{8'hA5}};
    vecs[0]  = mk(CMD_FLUSH, 32'h40, a5,         0, 0, 0,          0, 0, 0);
    vecs[1]  = mk(CMD_FLUSH, 32'h80, 128'h5555,  0, 0, 0,          0, 0, 0);
    vecs[2]  = mk(CMD_FLUSH, 32'hC0, 128'h7777,  0, 0, 0,          0, 0, 0);
    vecs[3]  = mk(CMD_RD,    32'h40, 0,          0, 0, 0,          1, a5, 32'h40);
    vecs[4]  = mk(CMD_RD,    32'h48, 0,          0, 0, 0,          1, a5, 32'h40);
    vecs[5]  = mk(CMD_RD,    32'h80, 0,          2, 32'h80, 128'h1234, 0, 0, 0);
    vecs[6]  = mk(CMD_RD,    32'h80, 0,          0, 0, 0,          1, 128'h1234, 32'h80);
    vecs[7]  = mk(CMD_RD,    32'h80, 0,          2, 32'hC0, 128'hDEAD, 1, 128'h1234, 32'h80);
    vecs[8]  = mk(CMD_RD,    32'hC0, 0,          0, 0, 0,          1, 128'h7777, 32'hC0);
    vecs[9]  = mk(CMD_RDX,   32'h4C, 0,          0, 0, 0,          1, a5, 32'h40);
    vecs[10] = mk(CMD_UPGR,  32'h40, 0,          0, 0, 0,          0, 0, 0);
    vecs[11] = mk(CMD_RD,    32'h40, 0,          0, 0, 0,          1, a5, 32'h40);

    drive_idle();
    repeat (2) @(negedge clk);
    check1("rst.busy", bus.mem_busy_o, 1'b0);
    check1("rst.rv", bus.resp_valid_o, 1'b0);
    check_v("rst.data", bus.resp_data_o, 128'd0);
    check_v("rst.addr", 128'(bus.resp_addr_o), 128'd0);
    check1("rst.err", bus.err_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), vecs[i]);
    check1("vec.err", bus.err_o, 1'b0);

    // Command during READ_WAIT is ignored but flagged.
    bus.bus_valid_i = 1'b1; bus.bus_cmd_i = CMD_RD; bus.bus_addr_i = 32'h40;
    @(negedge clk);
    bus.bus_valid_i = 1'b1; bus.bus_cmd_i = CMD_RD; bus.bus_addr_i = 32'h80;
    @(negedge clk);
    drive_idle();
    check1("err.set", bus.err_o, 1'b1);
    check1("err.busy", bus.mem_busy_o, 1'b1);
    repeat (LAT - 2) @(negedge clk);
    check1("err.rv", bus.resp_valid_o, 1'b1);
    check_v("err.data", bus.resp_data_o, a5);
    check_v("err.addr", 128'(bus.resp_addr_o), 128'h40);
    @(negedge clk);
    check1("err.idle", bus.mem_busy_o, 1'b0);
    check1("err.sticky", bus.err_o, 1'b1);

    // Random traffic against a line-granular memory model.
    for (int i = 0; i < 16; i++) begin
      d = rand128();
      a = $urandom();
      a[7:4] = 4'(i);
      run_txn("init", mk(CMD_FLUSH, a, d, 0, 0, 0, 0, 0, 0));
      ref_mem[i] = d;
    end
    for (int n = 0; n < 60; n++) begin
      op  = int'($urandom_range(0, 5));
      a   = $urandom();
      d   = rand128();
      idx = a[7:4];
      case (op)
        0, 1: run_txn("rnd_rd", mk(op == 0 ? CMD_RD : CMD_RDX, a, d, 0, 0, 0,
                                   1, ref_mem[idx], {a[31:4], 4'h0}));
        2: begin
          run_txn("rnd_wr", mk(CMD_FLUSH, a, d, 0, 0, 0, 0, 0, 0));
          ref_mem[idx] = d;
        end
        3: run_txn("rnd_upgr", mk(CMD_UPGR, a, d, 0, 0, 0, 0, 0, 0));
        default: begin
          fa = (op == 4) ? {a[31:4], 4'($urandom())} : $urandom();
          fd = rand128();
          fc = int'($urandom_range(1, LAT - 1));
          hit = (fa[31:4] == a[31:4]);
          run_txn("rnd_flush", mk(CMD_RD, a, d, fc, fa, fd,
                                  !hit, ref_mem[idx], {a[31:4], 4'h0}));
          if (hit) ref_mem[idx] = fd;
        end
      endcase
    end
    check1("rnd.err_sticky", bus.err_o, 1'b1);

    // Reset mid-READ_WAIT: immediate clear, no late response, memory kept.
    bus.bus_valid_i = 1'b1; bus.bus_cmd_i = CMD_RD; bus.bus_addr_i = 32'h40;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check1("arst.busy", bus.mem_busy_o, 1'b0);
    check1("arst.rv", bus.resp_valid_o, 1'b0);
    check_v("arst.data", bus.resp_data_o, 128'd0);
    check_v("arst.addr", 128'(bus.resp_addr_o), 128'd0);
    check1("arst.err", bus.err_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      check1("arst.no_rv", bus.resp_valid_o, 1'b0);
      check1("arst.no_busy", bus.mem_busy_o, 1'b0);
    end
    run_txn("arst.keep", mk(CMD_RD, 32'h40, 0, 0, 0, 0, 1, ref_mem[4], 32'h40));

    // Reset pulse during WRITE must leave the line untouched.
    bus.bus_valid_i = 1'b1; bus.bus_cmd_i = CMD_FLUSH; bus.bus_addr_i = 32'h40;
    bus.bus_data_i  = ~ref_mem[4];
    @(negedge clk);
    drive_idle();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check1("wrst.idle", bus.mem_busy_o, 1'b0);
    run_txn("wrst.keep", mk(CMD_RD, 32'h40, 0, 0, 0, 0, 1, ref_mem[4], 32'h40));
    check1("wrst.err", bus.err_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, bus address width.
REQ-002 SHALL have parameter CACHE_LINE_SIZE, default 128, line width in bits.
REQ-003 SHALL have parameter MEM_LINES, default 16, number of backing-store lines (power of two).
REQ-004 SHALL have parameter MEM_LATENCY, default 4, read latency in cycles (>=2).
REQ-005 SHALL have port clk_i  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port bus_valid_i  in  1  granted requester drives a bus command this cycle.
REQ-008 SHALL have port bus_cmd_i  in  2  command: RD=0, RDX=1, UPGR=2, FLUSH=3.
REQ-009 SHALL have port bus_addr_i  in  ADDR_SIZE  byte address of the transaction.
REQ-010 SHALL have port bus_data_i  in  CACHE_LINE_SIZE  line data for FLUSH/intervention.
REQ-011 SHALL have port bus_flush_i  in  1  snooping cache in M supplies the pending line (intervention).
REQ-012 SHALL have port mem_busy_o  out  1  responder not idle; arbiter withholds new grants.
REQ-013 SHALL have port resp_valid_o  out  1  one-cycle read-data strobe.
REQ-014 SHALL have port resp_data_o  out  CACHE_LINE_SIZE  read data, valid with resp_valid_o.
REQ-015 SHALL have port resp_addr_o  out  ADDR_SIZE  line-aligned address of the response.
REQ-016 SHALL have port err_o  out  1  sticky protocol-violation flag.

Function
REQ-017 SHALL implement states IDLE, READ_WAIT, RESPOND, WRITE.
REQ-018 Line index SHALL be bus_addr_i[OFF+IDX-1:OFF], OFF=log2(CACHE_LINE_SIZE/8), IDX=log2(MEM_LINES); upper bits ignored.
REQ-019 In IDLE with bus_valid_i and cmd RD or RDX, SHALL capture line address, load latency counter with MEM_LATENCY-2, enter READ_WAIT.
REQ-020 READ_WAIT SHALL decrement the counter each cycle and enter RESPOND when it is zero.
REQ-021 RESPOND SHALL assert resp_valid_o for exactly one cycle with mem[idx] and the captured address, then return to IDLE.
REQ-022 resp_valid_o SHALL be high in the cycle exactly MEM_LATENCY cycles after the accepting edge.
REQ-023 bus_flush_i high in READ_WAIT with bus_addr_i line matching the captured line SHALL write bus_data_i to mem[idx], suppress the response and return to IDLE next edge.
REQ-024 bus_flush_i with non-matching line, or outside READ_WAIT, SHALL be ignored.
REQ-025 In IDLE with bus_valid_i and cmd FLUSH, SHALL enter WRITE; WRITE SHALL write bus_data_i (captured at accept) to mem[idx] and return to IDLE after one cycle.
REQ-026 cmd UPGR SHALL cause no memory action and no state change.
REQ-027 mem_busy_o SHALL be high in every state except IDLE.
REQ-028 bus_valid_i high while not IDLE SHALL be ignored and SHALL set err_o, which stays high until reset.
REQ-029 resp_data_o and resp_addr_o SHALL be zero whenever resp_valid_o is low.

Reset
REQ-030 Reset SHALL force state IDLE, counter 0, mem_busy_o=0, resp_valid_o=0, resp_data_o=0, resp_addr_o=0, err_o=0, asynchronously.
REQ-031 Reset mid-READ_WAIT/RESPOND/WRITE SHALL abort without response; an incomplete WRITE SHALL not modify memory.
REQ-032 Backing-store contents SHALL be unaffected by reset and undefined after power-up.

Structure
REQ-033 Bus command encodings and ADDR_SIZE/CACHE_LINE_SIZE defaults SHALL live in shared package msi_pkg, shared with bus and cache.
REQ-034 Backing store SHALL be sub-module mem_array (synchronous write, combinational read, MEM_LINES x CACHE_LINE_SIZE).

Verification
REQ-035 FLUSH addr 0x40 data 0xA5..A5, then RD 0x40 -> resp_valid_o exactly 4 cycles after RD accept, resp_data_o=0xA5..A5, resp_addr_o=0x40.
REQ-036 RD 0x48 (same line as 0x40) -> resp_addr_o=0x40, same data; mem_busy_o high cycles 1..4 after accept.
REQ-037 RD 0x80, bus_flush_i at cycle 2 with addr 0x80 data 0x1234 -> no resp_valid_o, IDLE next cycle; later RD 0x80 returns 0x1234.
REQ-038 RD 0x80, flush with addr 0xC0 during wait -> response delivered normally from 0x80, mem[0xC0] unchanged.
REQ-039 bus_valid_i RD during READ_WAIT -> ignored, err_o=1 and sticky; UPGR in IDLE -> mem_busy_o stays 0.
REQ-040 rst_i pulsed mid-READ_WAIT -> all outputs 0 immediately, no resp_valid_o afterwards; memory retains prior data.
